// File: rtl/video_ctrl_pkg.sv
// video_ctrl_pkg: shared encodings, FSM states and defaults for video_proc_ctrl.
`default_nettype none

package video_ctrl_pkg;

  localparam logic [1:0] MODE_RGB  = 2'd0;
  localparam logic [1:0] MODE_GRAY = 2'd1;
  localparam logic [1:0] MODE_BIN  = 2'd2;

  localparam int TH_INIT_DEF = 100;
  localparam int TH_STEP_DEF = 5;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCUM  = 2'd1,
    ST_DIVIDE = 2'd2,
    ST_COMMIT = 2'd3
  } state_t;

  function automatic logic [1:0] next_mode(input logic [1:0] m);
    case (m)
      MODE_RGB:  return MODE_GRAY;
      MODE_GRAY: return MODE_BIN;
      default:   return MODE_RGB;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/key_debounce.sv
// key_debounce: two-flop synchroniser, stability counter and one-cycle press pulse.
`default_nettype none

module key_debounce #(
  parameter int DEBOUNCE_CYC = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYC + 1);

  logic          sync1;
  logic          sync2;
  logic          level;
  logic [CW-1:0] cnt;

  // The counter only runs while the synchronised input disagrees with the
  // debounced level, so DEBOUNCE_CYC consecutive equal samples flip it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      level <= 1'b0;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      press <= 1'b0;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYC - 1)) begin
        level <= sync2;
        cnt   <= '0;
        press <= sync2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/video_proc_ctrl.sv
// video_proc_ctrl: key-driven mode/threshold shadows committed at frame start.
// Define AUTO_TH_EN to add per-frame mean luminance as an automatic threshold.
`default_nettype none

import video_ctrl_pkg::*;

module video_proc_ctrl #(
  parameter int DEBOUNCE_CYC = 500000,
  parameter int TH_INIT      = TH_INIT_DEF,
  parameter int TH_STEP      = TH_STEP_DEF,
  parameter int CNT_W        = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] key,
  input  logic       i_vs,
  input  logic       i_de,
  input  logic [7:0] i_gray,
  output logic [1:0] o_mode,
  output logic [7:0] o_threshold,
  output logic       o_auto,
  output logic       o_update
);

  logic [2:0] press;

  generate
    for (genvar k = 0; k < 3; k++) begin : g_key
      key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (key[k]),
        .press (press[k])
      );
    end
  endgenerate

  logic [1:0] sh_mode;
  logic [7:0] sh_th;
  logic [8:0] th_up;
  logic [8:0] th_dn;
  logic       sh_auto;
  logic       vs_d;
  logic       vs_rise;
  state_t     state;
  state_t     state_nxt;
  logic [7:0] th_commit;
  logic       upd;

  assign th_up   = {1'b0, sh_th} + 9'(TH_STEP);
  assign th_dn   = {1'b0, sh_th} - 9'(TH_STEP);
  assign vs_rise = i_vs & ~vs_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sh_mode <= MODE_RGB;
      sh_th   <= 8'(TH_INIT);
      vs_d    <= 1'b0;
      state   <= ST_IDLE;
    end else begin
      vs_d  <= i_vs;
      state <= state_nxt;
      if (press[0]) sh_mode <= next_mode(sh_mode);
      // bit 8 of the sum/difference flags overflow or borrow
      if (press[1] && !press[2])      sh_th <= th_up[8] ? 8'hFF : th_up[7:0];
      else if (press[2] && !press[1]) sh_th <= th_dn[8] ? 8'h00 : th_dn[7:0];
    end
  end

`ifdef AUTO_TH_EN
  logic [CNT_W+7:0] sum;
  logic [CNT_W+7:0] rem;
  logic [CNT_W+7:0] dvs;
  logic [CNT_W-1:0] cnt;
  logic [7:0]       quot;
  logic [2:0]       div_cnt;
  logic             mean_ok;
  logic             auto_q;

  assign o_auto = auto_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sh_auto <= 1'b0;
      sum     <= '0;
      rem     <= '0;
      dvs     <= '0;
      cnt     <= '0;
      quot    <= '0;
      div_cnt <= '0;
      mean_ok <= 1'b0;
    end else begin
      if (press[1] && press[2]) sh_auto <= ~sh_auto;
      case (state)
        ST_ACCUM: begin
          if (vs_rise) begin
            rem     <= sum;
            dvs     <= {1'b0, cnt, 7'b0};
            mean_ok <= (cnt != '0);
            div_cnt <= '0;
            sum     <= '0;
            cnt     <= '0;
          end else if (i_de) begin
            sum <= sum + (CNT_W+8)'(i_gray);
            if (cnt != '1) cnt <= cnt + 1'b1;
          end
        end
        // restoring divide, one quotient bit per cycle, MSB first
        ST_DIVIDE: begin
          if (rem >= dvs) begin
            rem  <= rem - dvs;
            quot <= {quot[6:0], 1'b1};
          end else begin
            quot <= {quot[6:0], 1'b0};
          end
          dvs     <= dvs >> 1;
          div_cnt <= div_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end
`else
  logic unused_in;

  assign sh_auto   = 1'b0;
  assign o_auto    = 1'b0;
  assign unused_in = ^{i_de, i_gray};
`endif

  always_comb begin
    state_nxt = state;
    th_commit = sh_th;
    upd       = 1'b0;
    case (state)
      ST_IDLE:   if (vs_rise) state_nxt = ST_ACCUM;
`ifdef AUTO_TH_EN
      ST_ACCUM:  if (vs_rise) state_nxt = ST_DIVIDE;
      ST_DIVIDE: if (div_cnt == 3'd7) state_nxt = ST_COMMIT;
`else
      ST_ACCUM:  if (vs_rise) state_nxt = ST_COMMIT;
      ST_DIVIDE: state_nxt = ST_COMMIT;
`endif
      ST_COMMIT: state_nxt = ST_ACCUM;
      default:   state_nxt = ST_IDLE;
    endcase
`ifdef AUTO_TH_EN
    if (auto_q) th_commit = mean_ok ? quot : o_threshold;
`endif
    upd = (sh_mode != o_mode) || (th_commit != o_threshold) || (sh_auto != o_auto);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      o_mode      <= MODE_RGB;
      o_threshold <= 8'(TH_INIT);
      o_update    <= 1'b0;
`ifdef AUTO_TH_EN
      auto_q      <= 1'b0;
`endif
    end else begin
      o_update <= 1'b0;
      if (state == ST_COMMIT) begin
        o_mode      <= sh_mode;
        o_threshold <= th_commit;
        o_update    <= upd;
`ifdef AUTO_TH_EN
        auto_q      <= sh_auto;
`endif
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_video_proc_ctrl.sv
// tb_video_proc_ctrl: directed stimulus with a commit scoreboard for video_proc_ctrl.
`timescale 1ns/1ps
`default_nettype none

module tb_video_proc_ctrl;

`ifdef AUTO_TH_EN
  localparam int LAT  = 10;
  localparam bit AUTO = 1'b1;
`else
  localparam int LAT  = 2;
  localparam bit AUTO = 1'b0;
`endif

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] key   = 3'b000;
  logic       vs    = 1'b0;
  logic       de    = 1'b0;
  logic [7:0] gray  = 8'd0;
  logic [1:0] mode;
  logic [7:0] th;
  logic       auto_o;
  logic       upd;

  always #5 clk = ~clk;

  video_proc_ctrl #(
    .DEBOUNCE_CYC (4),
    .TH_INIT      (100),
    .TH_STEP      (5),
    .CNT_W        (20)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .key         (key),
    .i_vs        (vs),
    .i_de        (de),
    .i_gray      (gray),
    .o_mode      (mode),
    .o_threshold (th),
    .o_auto      (auto_o),
    .o_update    (upd)
  );

  typedef struct {
    int mode;
    int th;
    int auto_f;
    int upd;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // reference model: committed values, shadows, and the running frame sum
  int     m_mode, m_th, m_auto;
  int     m_sh_mode, m_sh_th, m_sh_auto;
  bit     m_armed;
  longint m_sum;
  int     m_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic model_reset();
    m_mode = 0; m_th = 100; m_auto = 0;
    m_sh_mode = 0; m_sh_th = 100; m_sh_auto = 0;
    m_armed = 1'b0; m_sum = 0; m_cnt = 0;
  endtask

  task automatic model_press(input bit k0, input bit k1, input bit k2);
    if (k0) m_sh_mode = (m_sh_mode + 1) % 3;
    if (k1 && !k2)      m_sh_th = (m_sh_th + 5 > 255) ? 255 : m_sh_th + 5;
    else if (k2 && !k1) m_sh_th = (m_sh_th - 5 < 0) ? 0 : m_sh_th - 5;
    else if (k1 && k2 && AUTO) m_sh_auto = 1 - m_sh_auto;
  endtask

  task automatic reset_dut();
    rst_n = 1'b0; key = 3'b000; vs = 1'b0; de = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(2);
    model_reset();
  endtask

  task automatic press(input int k);
    key[k] = 1'b1;
    tick(8);
    key[k] = 1'b0;
    tick(8);
    model_press(k == 0, k == 1, k == 2);
  endtask

  task automatic press_both();
    key[2:1] = 2'b11;
    tick(8);
    key[2:1] = 2'b00;
    tick(8);
    model_press(1'b0, 1'b1, 1'b1);
  endtask

  task automatic pixels(input int n, input int g);
    for (int i = 0; i < n; i++) begin
      de = 1'b1; gray = 8'(g);
      tick(1);
      m_sum += g; m_cnt++;
    end
    de = 1'b0;
  endtask

  // raise vs, predict the commit, then check before, at and after the commit edge
  task automatic vs_frame(input string tag);
    exp_t e;
    exp_t got;
    int   nth;
    if (!m_armed) begin
      m_armed = 1'b1;
      e.mode = m_mode; e.th = m_th; e.auto_f = m_auto; e.upd = 0;
    end else begin
      if (m_auto != 0) nth = (m_cnt > 0) ? int'(m_sum / m_cnt) : m_th;
      else             nth = m_sh_th;
      if (nth > 255) nth = 255;
      e.mode = m_sh_mode; e.th = nth; e.auto_f = m_sh_auto;
      e.upd = ((m_sh_mode != m_mode) || (nth != m_th) || (m_sh_auto != m_auto)) ? 1 : 0;
    end
    m_sum = 0; m_cnt = 0;
    sb.push_back(e);
    vs = 1'b1;
    tick(LAT - 1);
    chk({tag, " pre mode"}, 32'(mode), 32'(m_mode));
    chk({tag, " pre th"},   32'(th),   32'(m_th));
    chk({tag, " pre upd"},  32'(upd),  32'd0);
    tick(1);
    got = sb.pop_front();
    chk({tag, " mode"}, 32'(mode),   32'(got.mode));
    chk({tag, " th"},   32'(th),     32'(got.th));
    chk({tag, " auto"}, 32'(auto_o), 32'(got.auto_f));
    chk({tag, " upd"},  32'(upd),    32'(got.upd));
    m_mode = got.mode; m_th = got.th; m_auto = got.auto_f;
    tick(1);
    chk({tag, " upd end"}, 32'(upd), 32'd0);
    tick(2);
    vs = 1'b0;
    tick(3);
  endtask

  initial begin
    model_reset();
    reset_dut();
    chk("rst mode", 32'(mode),   32'd0);
    chk("rst th",   32'(th),     32'd100);
    chk("rst auto", 32'(auto_o), 32'd0);
    chk("rst upd",  32'(upd),    32'd0);

    vs_frame("arm");
    pixels(50, 10);
    vs_frame("idle1");
    pixels(50, 200);
    vs_frame("idle2");

    pixels(20, 30);
    press(0);
    chk("mode held mid-frame", 32'(mode), 32'd0);
    pixels(20, 30);
    vs_frame("mode1");
    press(0);
    vs_frame("mode2");
    press(0);
    vs_frame("mode0");

    repeat (26) press(1);
    vs_frame("th230");
    repeat (7) press(1);
    vs_frame("th255 sat");
    press(2);
    vs_frame("th250");

    key[1] = 1'b1; key[2] = 1'b1;
    tick(2);
    key[2] = 1'b0;
    tick(6);
    key[1] = 1'b0;
    tick(8);
    model_press(1'b0, 1'b1, 1'b0);
    vs_frame("glitch");

    reset_dut();
    vs_frame("rearm");
    pixels(10, 50);
    press(1);
    press(1);
    pixels(10, 50);
    reset_dut();
    vs_frame("rearm2");
    vs_frame("after rst");

    repeat (21) press(2);
    vs_frame("th0 sat");

    press_both();
    pixels(1024, 60);
    vs_frame("auto on");
    pixels(1024, 60);
    vs_frame("auto mean");
    vs_frame("auto no de");
    press_both();
    vs_frame("auto off");
    vs_frame("manual restore");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/video_proc_ctrl.md
Name: video_proc_ctrl

Overview:
- Control-plane sequencer for the RGB565 → gray → binary display datapath.
- Debounces the three raw board keys and keeps shadow copies of display mode and binarisation threshold.
- Commits the shadow copies to the datapath only at frame start, so there is never a mid-frame tear.
- Optionally computes a per-frame mean luminance and uses it as an automatic threshold.

Parameters:
- DEBOUNCE_CYC, 500000, clk cycles a raw key must be stable before its debounced level changes.
- TH_INIT, 100, threshold value after reset.
- TH_STEP, 5, threshold increment/decrement per key press.
- CNT_W, 20, width of the per-frame pixel counter (sum width = CNT_W+8).

Ports:
- clk  in  1  pixel clock.
- rst_n  in  1  synchronous active-low reset.
- key  in  3  raw active-high keys: [0] next mode, [1] threshold up, [2] threshold down.
- i_vs  in  1  vertical sync, active high; its rising edge marks frame start.
- i_de  in  1  active-video enable.
- i_gray  in  8  gray value of the current pixel, from the datapath.
- o_mode  out  2  committed mode: 0 RGB, 1 gray, 2 binary.
- o_threshold  out  8  committed threshold.
- o_auto  out  1  auto-threshold active (constant 0 without the macro).
- o_update  out  1  one-cycle pulse on the cycle the committed values change.

Behaviour:
- Reset (sync, rst_n low at a clk edge) values:
  - o_mode=0, o_threshold=TH_INIT, o_auto=0, o_update=0.
  - Shadow mode=0, shadow threshold=TH_INIT, debounced keys=0.
  - Accumulators cleared; FSM → IDLE.
  - A reset mid-frame discards any pending edits and any partial sum.
- Debounce, per key:
  - Two-flop synchroniser, then a stability counter.
  - The debounced level changes after DEBOUNCE_CYC consecutive equal samples.
  - A press event is a one-cycle pulse on the debounced 0→1 edge. Releases generate nothing.
- Shadow update, in the same cycle as the press event:
  - key0: shadow mode 0→1→2→0.
  - key1: shadow threshold += TH_STEP, saturating at 255.
  - key2: shadow threshold -= TH_STEP, saturating at 0.
  - key1 and key2 events in the same cycle: threshold unchanged. See the Optional Feature for the macro case.
  - Several presses within one frame accumulate in the shadow.
- Frame-start detect: registered i_vs; vs_rise = i_vs & ~vs_d.
- FSM, states IDLE, ACCUM, DIVIDE, COMMIT:
  - IDLE → ACCUM on the first vs_rise after reset. Nothing commits before that.
  - ACCUM: on every i_de cycle, sum += i_gray and cnt += 1. cnt saturates at all-ones; the sum keeps accumulating.
  - ACCUM → DIVIDE on vs_rise. The sum/cnt snapshot is latched and the accumulators are cleared in the same cycle.
  - DIVIDE: 8-cycle serial restoring divide producing an 8-bit quotient, the mean gray level. Then → COMMIT.
    - Without the macro, DIVIDE lasts 0 cycles (straight to COMMIT).
  - COMMIT: one cycle, then → ACCUM.
    - o_mode ← shadow mode.
    - o_threshold ← (o_auto ? mean : shadow threshold).
    - o_update=1 only if a committed value differs from its previous value.
  - Total latency from vs_rise to updated outputs: 10 cycles with the macro, 2 without. vs must stay high at least that long.
- cnt==0 at the snapshot (frame with no DE): the mean is invalid and the auto path keeps the previous o_threshold.
- A key press during DIVIDE or COMMIT updates the shadow only. It commits at the next frame start.
- A vs_rise arriving while in DIVIDE is ignored (frame-rate violation) and the accumulators are not cleared by it. Such a vs_rise is ignored in COMMIT likewise.

Optional Feature:
- AUTO_TH_EN defined:
  - key1 and key2 press events in the same cycle toggle a shadow auto flag. The flag is committed to o_auto at COMMIT.
  - When o_auto=1, o_threshold follows the previous frame's mean luminance, computed by the divider.
  - The shadow threshold is retained and restored when auto is switched off.
- AUTO_TH_EN undefined:
  - No accumulator or divider logic.
  - o_auto tied 0.
  - Simultaneous key1 and key2 presses are a no-op.

Decomposition:
- Package video_ctrl_pkg:
  - Mode encodings MODE_RGB=0, MODE_GRAY=1, MODE_BIN=2.
  - FSM state typedef.
  - TH_INIT/TH_STEP defaults.
- Sub-module key_debounce (synchroniser + counter + edge pulse), instantiated three times.
- The divider stays inline.

Test Plan (DEBOUNCE_CYC=4):
- Reset then three vs frames with no keys → o_mode=0, o_threshold=100, o_update never asserted.
- One key0 press mid-frame → o_mode stays 0 until the next vs_rise, then becomes 1 with a single o_update pulse. Two more presses in the next frames → 2, then 0.
- Seven key1 presses in one frame from threshold 230 → committed threshold 255, saturated.
- Key1 press with a 2-cycle glitch on key2 → threshold +5 only; the glitch is filtered.
- Reset asserted mid-frame after two key1 presses → threshold 100 at the next commit, not 110.
- AUTO_TH_EN, key1+key2 together, frame of 1024 DE pixels all gray 60 → after the next vs_rise o_auto=1; one frame later o_threshold=60. Zero-DE frame → threshold held at 60.
